alu_pipe: RTL and testbench

//   Parametrised, handshaked successor to the 16-bit single-cycle ALU of the I2O2 CPU datapath.

---
 rtl/alu_pipe.sv | 129 ++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready-handshaked ALU with immediates and an iterative shift-add multiply.
// Non-mul ops register in one cycle; mul takes WIDTH cycles in MUL, parking in WAIT if the output is busy.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       codop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             neg,
    output logic             zero,
    output logic             overflow,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand, r_mplier, r_out;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_valid, r_neg, r_zero, r_ovf, r_err;

    logic               w_free, w_accept, w_last, w_load_alu, w_load_mul, w_load;
    logic               w_sub, w_ar_ovf, w_ovf, w_err;
    logic [WIDTH-1:0]   w_sext, w_zext, w_y, w_yx, w_sum, w_res, w_ld_res;
    logic [2*WIDTH-1:0] w_add, w_acc, w_prod;

    assign w_free     = !r_valid || out_ready;
    assign in_ready   = (r_state == S_IDLE) && w_free;
    assign w_accept   = in_valid && in_ready;
    assign w_last     = r_cnt == CW'(WIDTH - 1);
    assign w_load_alu = w_accept && codop != 4'd11;
    assign w_load_mul = w_free && ((r_state == S_MUL && w_last) || r_state == S_WAIT);
    assign w_load     = w_load_alu || w_load_mul;

    // One adder serves add/sub/addi/subi: subtraction is b + ~y + 1, so the
    // usual same-sign overflow rule applies to the inverted operand.
    assign w_sext   = WIDTH'($signed(a[IMM_W-1:0]));
    assign w_zext   = WIDTH'(a[IMM_W-1:0]);
    assign w_sub    = codop == 4'd1 || codop == 4'd10;
    assign w_y      = (codop == 4'd9 || codop == 4'd10) ? w_sext : a;
    assign w_yx     = w_sub ? ~w_y : w_y;
    assign w_sum    = b + w_yx + WIDTH'(w_sub);
    assign w_ar_ovf = (b[WIDTH-1] == w_yx[WIDTH-1]) && (w_sum[WIDTH-1] != b[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (codop)
            4'd0, 4'd1, 4'd9, 4'd10: begin
                w_res = w_sum;
                w_ovf = w_ar_ovf;
            end
            4'd2:    w_res = WIDTH'($signed(b) < $signed(a));
            4'd3:    w_res = a & b;
            4'd4:    w_res = a | b;
            4'd5:    w_res = a ^ b;
            4'd6:    w_res = b & w_zext;
            4'd7:    w_res = b | w_zext;
            4'd8:    w_res = b ^ w_zext;
            4'd11:   w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    assign w_add    = r_mplier[r_cnt] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_acc    = r_acc + w_add;
    assign w_prod   = (r_state == S_MUL) ? w_acc : r_acc;
    assign w_ld_res = w_load_alu ? w_res : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_out    <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept && codop == 4'd11) begin
                    r_mcand  <= a;
                    r_mplier <= b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_state  <= S_MUL;
                end
                S_MUL: begin
                    r_acc <= w_acc;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_state <= w_free ? S_IDLE : S_WAIT;
                end
                S_WAIT:  if (w_free) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            r_valid <= w_load ? 1'b1 : (out_ready ? 1'b0 : r_valid);
            if (w_load) begin
                r_out  <= w_ld_res;
                r_neg  <= w_ld_res[WIDTH-1];
                r_zero <= w_ld_res == '0;
                r_ovf  <= w_load_alu ? w_ovf : |w_prod[2*WIDTH-1:WIDTH];
                r_err  <= w_load_alu && w_err;
            end
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign neg       = r_neg;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign err       = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; expected results are queued at acceptance
// and compared whenever the DUT hands a result to the consumer.
module tb_alu_pipe;
    typedef struct packed {
        logic [15:0] o;
        logic        n, z, v, e;
    } res_t;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, neg, zero, overflow, err;
    logic [3:0]  codop = '0;
    logic [15:0] a = '0, b = '0, out;
    int          checks = 0, errors = 0;
    res_t        q[$];

    alu_pipe #(.WIDTH(16), .IMM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .codop(codop), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .neg(neg), .zero(zero), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
        res_t   r;
        logic [7:0] im;
        int     sa, sb, si, s;
        longint p;
        im = av[7:0];
        sa = int'($signed(av));
        sb = int'($signed(bv));
        si = int'($signed(im));
        r  = '0;
        s  = 0;
        case (op)
            4'd0:  s = sb + sa;
            4'd1:  s = sb - sa;
            4'd9:  s = sb + si;
            4'd10: s = sb - si;
            default: s = 0;
        endcase
        case (op)
            4'd0, 4'd1, 4'd9, 4'd10: begin
                r.o = s[15:0];
                r.v = (s > 32767) || (s < -32768);
            end
            4'd2:  r.o = (sb < sa) ? 16'd1 : 16'd0;
            4'd3:  r.o = av & bv;
            4'd4:  r.o = av | bv;
            4'd5:  r.o = av ^ bv;
            4'd6:  r.o = bv & {8'h00, im};
            4'd7:  r.o = bv | {8'h00, im};
            4'd8:  r.o = bv ^ {8'h00, im};
            4'd11: begin
                p   = longint'(av) * longint'(bv);
                r.o = p[15:0];
                r.v = p[31:16] != 16'h0;
            end
            default: r.e = 1'b1;
        endcase
        r.n = r.o[15];
        r.z = r.o == 16'h0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out=%h with nothing expected", out);
            end else begin
                res_t exp;
                exp = q.pop_front();
                if ({out, neg, zero, overflow, err} !== exp)
                    begin
                        errors++;
                        $display("FAIL sb_result: got out=%h n=%b z=%b v=%b e=%b, want out=%h n=%b z=%b v=%b e=%b",
                                 out, neg, zero, overflow, err, exp.o, exp.n, exp.z, exp.v, exp.e);
                    end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv, output int waited);
        codop = op; a = av; b = bv; in_valid = 1'b1; waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: op=%0d never accepted", op);
        end else q.push_back(model(op, av, bv));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out, neg, zero, overflow, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b out=%h n=%b z=%b v=%b e=%b, want all 0",
                     out_valid, out, neg, zero, overflow, err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int w;
        out_ready = 1'b1;
        send(4'd0, 16'd170, 16'd255, w);
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd425) begin
            errors++;
            $display("FAIL add_latency: valid=%b out=%0d, want valid=1 out=425", out_valid, out);
        end
        for (int i = 1; i <= 5; i++) begin
            send(4'(i), 16'd170, 16'd255, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL back_to_back op%0d: waited %0d cycles, want 0", i, w);
            end
        end
        drain();
    endtask

    task automatic test_arith();
        int w;
        send(4'd1, 16'd170, 16'd255, w);
        send(4'd1, 16'd255, 16'd170, w);
        send(4'd0, 16'h7FFF, 16'd1, w);
        send(4'd2, 16'd255, 16'd170, w);
        send(4'd2, 16'hFFFF, 16'd0, w);
        send(4'd1, 16'd1, 16'h8000, w);
        drain();
    endtask

    task automatic test_imm();
        int w;
        send(4'd9, 16'h00AA, 16'd255, w);
        send(4'd10, 16'h00AA, 16'd255, w);
        send(4'd6, 16'h00AA, 16'hFFFF, w);
        send(4'd8, 16'h00AA, 16'h00AA, w);
        send(4'd7, 16'h1234, 16'h0F00, w);
        drain();
    endtask

    task automatic test_mul();
        int w, n;
        send(4'd11, 16'd300, 16'd300, w);
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL mul_busy: in_ready low for %0d cycles, want 16", n);
        end
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd24464 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mul_result: valid=%b out=%0d v=%b, want valid=1 out=24464 v=1", out_valid, out, overflow);
        end
        send(4'd11, 16'd12, 16'd10, w);
        send(4'd11, 16'hFFFF, 16'hFFFF, w);
        drain();
    endtask

    task automatic test_backpressure();
        int w;
        logic [15:0] held;
        out_ready = 1'b0;
        send(4'd0, 16'd1, 16'd2, w);
        held = out;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== held) begin
                errors++;
                $display("FAIL hold%0d: in_ready=%b valid=%b out=%h, want 0 1 %h", i, in_ready, out_valid, out, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_clear: valid=%b want 0", out_valid);
        end
        send(4'd11, 16'd12, 16'd10, w);
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out !== 16'd120 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_held: valid=%b out=%0d in_ready=%b, want 1 120 0", out_valid, out, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_release: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        int w;
        send(4'd11, 16'd300, 16'd300, w);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if ({out_valid, out, neg, zero, overflow, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul: valid=%b out=%h n=%b z=%b v=%b e=%b, want all 0",
                     out_valid, out, neg, zero, overflow, err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", in_ready);
        end
        send(4'd0, 16'd1, 16'd1, w);
        checks++;
        if (out !== 16'd2) begin
            errors++;
            $display("FAIL post_reset_add: out=%0d want 2", out);
        end
        send(4'd14, 16'd5, 16'd7, w);
        checks++;
        if (err !== 1'b1 || out !== 16'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: err=%b out=%h zero=%b, want 1 0000 1", err, out, zero);
        end
        send(4'd12, 16'd5, 16'd7, w);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_imm();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
